task_scheduler: RTL

//  Sequences Othello solve tasks into the endgame `pipeline` ring, a fixed set of SLOTS in-flight positions.

---
 rtl/othello_pkg.sv | 35 +++
 rtl/result_fifo.sv | 65 ++++++
 rtl/task_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/othello_pkg.sv
// Shared types and constants for the Othello endgame task scheduler.
package othello_pkg;

  localparam logic [15:0] FILLER_ID = 16'hFFFF;
  localparam logic [63:0] FILLER_P  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FILLER_O  = 64'h0;

  typedef struct packed {
    logic [63:0] p;
    logic [63:0] o;
    logic [15:0] id;
  } task_t;

  typedef struct packed {
    logic [15:0]        id;
    logic signed [7:0]  res;
  } result_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN
  } sched_state_e;

  // A full board: the pipeline finishes it at once and hands back FILLER_ID.
  function automatic task_t filler_task();
    task_t t;
    t.p  = FILLER_P;
    t.o  = FILLER_O;
    t.id = FILLER_ID;
    return t;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO for solved results. Push and pop may coincide even when full.
module result_fifo
  import othello_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  result_t       push_data,
  input  logic          pop,
  output result_t       head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  result_t       mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Pointer and occupancy update; a push into a full FIFO is only taken alongside a pop.
  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
    if (do_pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/task_scheduler.sv
// Feeds Othello solve tasks into the fixed-depth endgame pipeline ring and
// collects solved results into a buffered result stream.
module task_scheduler
  import othello_pkg::*;
#(
  parameter int SLOTS     = 9,
  parameter int RES_DEPTH = 16
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iStart,
  input  logic               iStop,
  input  logic               iTaskValid,
  output logic               oTaskReady,
  input  logic [63:0]        iTaskPlayer,
  input  logic [63:0]        iTaskOpp,
  input  logic [15:0]        iTaskId,
  output logic               oEnable,
  output logic               oValid,
  output logic [63:0]        oPlayer,
  output logic [63:0]        oOpponent,
  output logic [15:0]        oTaskid,
  input  logic               iSolved,
  input  logic [15:0]        iTaskidOut,
  input  logic signed [7:0]  iRes,
  output logic               oResValid,
  input  logic               iResReady,
  output logic [15:0]        oResTaskid,
  output logic signed [7:0]  oRes,
  output logic               oBusy,
  output logic               oErr
);

  localparam int OW = $clog2(SLOTS + 1);
  localparam int FW = $clog2(SLOTS + 1);
  localparam int CW = $clog2(RES_DEPTH + 1);

  sched_state_e  state_q, state_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  logic          stop_pend_q, stop_pend_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic          err_q, err_d;
  task_t         offer_q, offer_d;

  logic          consume;
  logic          accepting;
  logic          real_solve;
  logic          credit_ok;
  logic          slot_ok;
  logic          take;
  logic          issue;
  logic          res_pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  result_t       fifo_head;
  result_t       push_data;

  // Handshake decisions: when a ring slot is refilled and whether the upstream task is taken.
  // Admission also keeps the in-flight count within the ring so the counter never saturates.
  always_comb begin
    consume    = (state_q == ST_FILL) ||
                 (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && iSolved);
    accepting  = ((state_q == ST_FILL) || (state_q == ST_RUN)) && !stop_pend_q && !iStop;
    real_solve = iSolved && (iTaskidOut != FILLER_ID);
    credit_ok  = (int'(fifo_count) + int'(outstanding_q) + 1) <= RES_DEPTH;
    slot_ok    = (int'(outstanding_q) < SLOTS) || real_solve;
    take       = consume && accepting && iTaskValid && credit_ok && slot_ok;
    issue      = take && (iTaskId != FILLER_ID);
    res_pop    = !fifo_empty && iResReady;
    push_data.id  = iTaskidOut;
    push_data.res = iRes;
  end

  // Next-state logic for the sequencing FSM and its fill counter.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart && !iStop) begin
          state_d     = ST_FILL;
          fill_cnt_d  = '0;
          stop_pend_d = 1'b0;
        end
      end
      ST_FILL: begin
        if (iStop) stop_pend_d = 1'b1;
        if (fill_cnt_q == FW'(SLOTS - 1)) begin
          state_d = (stop_pend_q || iStop) ? ST_DRAIN : ST_RUN;
        end else begin
          fill_cnt_d = fill_cnt_q + FW'(1);
        end
      end
      ST_RUN: begin
        if (iStop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((outstanding_q == '0) && fifo_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // In-flight accounting and the sticky error flag.
  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q;
    case ({issue, real_solve})
      2'b10: begin
        if (outstanding_q != OW'(SLOTS)) outstanding_d = outstanding_q + OW'(1);
      end
      2'b01: begin
        if (outstanding_q == '0) err_d = 1'b1;
        else                     outstanding_d = outstanding_q - OW'(1);
      end
      default: outstanding_d = outstanding_q;
    endcase
    if (take && (iTaskId == FILLER_ID)) err_d = 1'b1;
  end

  // Offer register: loads the admitted task or a filler on every slot refill.
  always_comb begin
    offer_d = offer_q;
    if (consume) begin
      if (issue) begin
        offer_d.p  = iTaskPlayer;
        offer_d.o  = iTaskOpp;
        offer_d.id = iTaskId;
      end else begin
        offer_d = filler_task();
      end
    end
  end

  // Control and offer registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q       <= ST_IDLE;
      fill_cnt_q    <= '0;
      stop_pend_q   <= 1'b0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      offer_q       <= filler_task();
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      stop_pend_q   <= stop_pend_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      offer_q       <= offer_d;
    end
  end

  result_fifo #(
    .DEPTH(RES_DEPTH)
  ) u_result_fifo (
    .clk       (iCLOCK),
    .rst_n     (inRESET),
    .push      (real_solve),
    .push_data (push_data),
    .pop       (res_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign oTaskReady = take;
  assign oEnable    = (state_q != ST_IDLE);
  assign oValid     = (state_q != ST_IDLE);
  assign oBusy      = (state_q != ST_IDLE);
  assign oPlayer    = offer_q.p;
  assign oOpponent  = offer_q.o;
  assign oTaskid    = offer_q.id;
  assign oResValid  = !fifo_empty;
  assign oResTaskid = fifo_head.id;
  assign oRes       = fifo_head.res;
  assign oErr       = err_q || (fifo_full && 1'b0);

endmodule
